seg_set_ctrl: RTL and testbench

//   Time-setting controller for the 6-digit clock display. Sequences the user through

---
 rtl/seg_set_ctrl.sv | 106 ++++++++++
 tb/tb_seg_set_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seg_set_ctrl.sv
// seg_set_ctrl: hour/min/sec time-setting FSM with shadow fields, flash enables and commit strobe.
// Define SEG_SET_DEC_EN to add the key_dec port for decrementing the active field.
module seg_set_ctrl #(
    parameter int TIMEOUT_S = 10,
    parameter int HOUR_MAX  = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
`ifdef SEG_SET_DEC_EN
    input  logic       key_dec,
`endif
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       edit_active,
    output logic [1:0] field_sel,
    output logic [5:0] flash_mask,
    output logic [4:0] disp_hour,
    output logic [5:0] disp_min,
    output logic [5:0] disp_sec,
    output logic       load_en,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic [5:0] load_sec
);
    localparam logic [2:0] IDLE = 3'd0, EDIT_H = 3'd1, EDIT_M = 3'd2, EDIT_S = 3'd3, COMMIT = 3'd4;
    localparam logic [5:0] TMO = 6'(TIMEOUT_S);
    localparam logic [4:0] HM  = 5'(HOUR_MAX);
    logic [2:0] state, nxt;
    logic [4:0] sh_hour;
    logic [5:0] sh_min, sh_sec, tcnt;
    logic kd, key_any, bump, drop, editing, nxt_edit, timeout;
`ifdef SEG_SET_DEC_EN
    assign kd = key_dec;
`else
    assign kd = 1'b0;
`endif
    assign key_any  = key_mode | key_inc | kd;
    assign bump     = key_inc & ~kd;
    assign drop     = kd & ~key_inc;
    assign editing  = (state == EDIT_H) || (state == EDIT_M) || (state == EDIT_S);
    assign nxt_edit = (nxt == EDIT_H) || (nxt == EDIT_M) || (nxt == EDIT_S);
    assign timeout  = editing && !key_any && (tcnt >= TMO);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = key_mode ? EDIT_H : IDLE;
            EDIT_H:  nxt = key_mode ? EDIT_M : timeout ? IDLE : EDIT_H;
            EDIT_M:  nxt = key_mode ? EDIT_S : timeout ? IDLE : EDIT_M;
            EDIT_S:  nxt = key_mode ? COMMIT : timeout ? IDLE : EDIT_S;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            edit_active <= 1'b0;
            field_sel   <= 2'd0;
            flash_mask  <= 6'd0;
            load_en     <= 1'b0;
            load_hour   <= 5'd0;
            load_min    <= 6'd0;
            load_sec    <= 6'd0;
            sh_hour     <= 5'd0;
            sh_min      <= 6'd0;
            sh_sec      <= 6'd0;
            tcnt        <= 6'd0;
        end else begin
            state       <= nxt;
            edit_active <= nxt_edit;
            field_sel   <= nxt_edit ? nxt[1:0] : 2'd0;
            flash_mask  <= nxt == EDIT_H ? 6'b110000 : nxt == EDIT_M ? 6'b001100 :
                           nxt == EDIT_S ? 6'b000011 : 6'b000000;
            load_en     <= nxt == COMMIT;
            if (state == EDIT_S && key_mode) begin
                load_hour <= sh_hour;
                load_min  <= sh_min;
                load_sec  <= sh_sec;
            end
            if (state == IDLE && key_mode) begin
                sh_hour <= cur_hour;
                sh_min  <= cur_min;
                sh_sec  <= cur_sec;
            end else if (!key_mode && state == EDIT_H)
                sh_hour <= bump ? (sh_hour >= HM ? 5'd0 : sh_hour + 5'd1) :
                           drop ? (sh_hour == 5'd0 ? HM : sh_hour - 5'd1) : sh_hour;
            else if (!key_mode && state == EDIT_M)
                sh_min <= bump ? (sh_min >= 6'd59 ? 6'd0 : sh_min + 6'd1) :
                          drop ? (sh_min == 6'd0 ? 6'd59 : sh_min - 6'd1) : sh_min;
            else if (!key_mode && state == EDIT_S)
                sh_sec <= bump ? (sh_sec >= 6'd59 ? 6'd0 : sh_sec + 6'd1) :
                          drop ? (sh_sec == 6'd0 ? 6'd59 : sh_sec - 6'd1) : sh_sec;
            // key presses take priority over the 1 Hz tick so a press always restarts the count
            if (!nxt_edit || state == IDLE || key_any)
                tcnt <= 6'd0;
            else if (tick_1hz && tcnt != 6'd63)
                tcnt <= tcnt + 6'd1;
        end
    end
    assign disp_hour = edit_active ? sh_hour : cur_hour;
    assign disp_min  = edit_active ? sh_min  : cur_min;
    assign disp_sec  = edit_active ? sh_sec  : cur_sec;
endmodule

// File: tb/tb_seg_set_ctrl.sv
// tb_seg_set_ctrl: directed checks of entry, edit, wrap, timeout, key priority and reset.
module tb_seg_set_ctrl;
    logic clk = 0, rst = 1, tick_1hz = 0, key_mode = 0, key_inc = 0, key_dec = 0;
    logic [4:0] cur_hour = 12;
    logic [5:0] cur_min = 34, cur_sec = 56;
    logic edit_active, load_en;
    logic [1:0] field_sel;
    logic [5:0] flash_mask, disp_min, disp_sec, load_min, load_sec;
    logic [4:0] disp_hour, load_hour;
    int checks = 0, errors = 0, loads = 0;

    seg_set_ctrl dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .key_mode(key_mode), .key_inc(key_inc),
`ifdef SEG_SET_DEC_EN
        .key_dec(key_dec),
`endif
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .edit_active(edit_active), .field_sel(field_sel), .flash_mask(flash_mask),
        .disp_hour(disp_hour), .disp_min(disp_min), .disp_sec(disp_sec),
        .load_en(load_en), .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec));

    always #5 clk = ~clk;
    always @(negedge clk) if (load_en) loads++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic m, input logic i, input logic d, input logic t);
        key_mode = m; key_inc = i; key_dec = d; tick_1hz = t;
        step();
        key_mode = 0; key_inc = 0; key_dec = 0; tick_1hz = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) step();
        rst = 0;
        checks++; if ({edit_active, field_sel, flash_mask, load_en} !== 10'd0) begin errors++;
            $display("FAIL reset_ctrl got %b want 0", {edit_active, field_sel, flash_mask, load_en}); end
        checks++; if ({load_hour, load_min, load_sec} !== 17'd0) begin errors++;
            $display("FAIL reset_load got %h want 0", {load_hour, load_min, load_sec}); end
        checks++; if ({disp_hour, disp_min, disp_sec} !== {5'd12, 6'd34, 6'd56}) begin errors++;
            $display("FAIL reset_disp got %0d:%0d:%0d want 12:34:56", disp_hour, disp_min, disp_sec); end
    endtask

    task automatic test_commit();
        pulse(1, 0, 0, 0);
        checks++; if ({edit_active, field_sel, flash_mask} !== {1'b1, 2'd1, 6'b110000}) begin errors++;
            $display("FAIL enter_h got %b want 1_01_110000", {edit_active, field_sel, flash_mask}); end
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        checks++; if (disp_hour !== 5'd14) begin errors++;
            $display("FAIL inc_hour got %0d want 14", disp_hour); end
        pulse(1, 0, 0, 0);
        checks++; if ({field_sel, flash_mask} !== {2'd2, 6'b001100}) begin errors++;
            $display("FAIL enter_m got %b want 10_001100", {field_sel, flash_mask}); end
        pulse(0, 1, 0, 0);
        checks++; if (disp_min !== 6'd35) begin errors++;
            $display("FAIL inc_min got %0d want 35", disp_min); end
        pulse(1, 0, 0, 0);
        checks++; if ({field_sel, flash_mask} !== {2'd3, 6'b000011}) begin errors++;
            $display("FAIL enter_s got %b want 11_000011", {field_sel, flash_mask}); end
        pulse(1, 0, 0, 0);
        checks++; if ({load_en, flash_mask, field_sel, edit_active} !== {1'b1, 9'd0}) begin errors++;
            $display("FAIL commit got %b want 1_000000000", {load_en, flash_mask, field_sel, edit_active}); end
        checks++; if ({load_hour, load_min, load_sec} !== {5'd14, 6'd35, 6'd56}) begin errors++;
            $display("FAIL load_val got %0d:%0d:%0d want 14:35:56", load_hour, load_min, load_sec); end
        step();
        checks++; if ({load_en, load_hour} !== {1'b0, 5'd14}) begin errors++;
            $display("FAIL load_hold got en=%b h=%0d want en=0 h=14", load_en, load_hour); end
    endtask

    task automatic test_wrap();
        cur_hour = 23; cur_min = 59; cur_sec = 0;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        checks++; if (disp_hour !== 5'd0) begin errors++;
            $display("FAIL wrap_hour got %0d want 0", disp_hour); end
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        checks++; if (disp_min !== 6'd0) begin errors++;
            $display("FAIL wrap_min got %0d want 0", disp_min); end
        pulse(1, 0, 0, 0);
`ifdef SEG_SET_DEC_EN
        pulse(0, 0, 1, 0);
        checks++; if (disp_sec !== 6'd59) begin errors++;
            $display("FAIL wrap_sec_dec got %0d want 59", disp_sec); end
`endif
        pulse(1, 0, 0, 0);
        step();
        cur_hour = 30;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        checks++; if (disp_hour !== 5'd0) begin errors++;
            $display("FAIL wrap_oor got %0d want 0", disp_hour); end
        rst = 1; step(); rst = 0;
        cur_hour = 12; cur_min = 34; cur_sec = 56;
    endtask

    task automatic test_timeout();
        int l0 = loads;
        pulse(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin pulse(0, 0, 0, 1); step(); end
        repeat (3) step();
        checks++; if (edit_active !== 1'b1) begin errors++;
            $display("FAIL tmo_9ticks got %b want 1", edit_active); end
        pulse(0, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin pulse(0, 0, 0, 1); step(); end
        repeat (3) step();
        checks++; if (edit_active !== 1'b1) begin errors++;
            $display("FAIL tmo_restart got %b want 1", edit_active); end
        pulse(0, 0, 0, 1);
        repeat (3) step();
        checks++; if ({edit_active, field_sel, flash_mask} !== 9'd0) begin errors++;
            $display("FAIL tmo_abort got %b want 0", {edit_active, field_sel, flash_mask}); end
        checks++; if (loads !== l0 || disp_hour !== 5'd12) begin errors++;
            $display("FAIL tmo_noload got loads=%0d h=%0d want loads=%0d h=12", loads, disp_hour, l0); end
    endtask

    task automatic test_simul();
        cur_hour = 5;
        pulse(1, 0, 0, 0);
        pulse(1, 1, 0, 0);
        checks++; if ({field_sel, disp_hour} !== {2'd2, 5'd5}) begin errors++;
            $display("FAIL mode_inc got sel=%0d h=%0d want sel=2 h=5", field_sel, disp_hour); end
`ifdef SEG_SET_DEC_EN
        pulse(0, 1, 1, 0);
        checks++; if (disp_min !== 6'd34) begin errors++;
            $display("FAIL inc_dec got %0d want 34", disp_min); end
`endif
    endtask

    task automatic test_rst_mid();
        int l0 = loads;
        rst = 1;
        step();
        rst = 0;
        checks++; if ({edit_active, field_sel, flash_mask, load_en, load_hour} !== 15'd0) begin errors++;
            $display("FAIL rst_mid got %b want 0", {edit_active, field_sel, flash_mask, load_en, load_hour}); end
        step();
        checks++; if (loads !== l0 || disp_hour !== 5'd5) begin errors++;
            $display("FAIL rst_noload got loads=%0d h=%0d want loads=%0d h=5", loads, disp_hour, l0); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_wrap();
        test_timeout();
        test_simul();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
